shift_reg_universal: RTL
========================

SHIFT_REG_UNIVERSAL -- requirements
Module: shift_reg_universal

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port CLR, input, 1 bit, reset, asynchronous and active-high.
REQ-004 The block SHALL have port mode, input, 2 bits, operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-005 The block SHALL have port D, input, WIDTH bits, parallel load data.
REQ-006 The block SHALL have port SIR, input, 1 bit, serial input entering the MSB on shift right.
REQ-007 The block SHALL have port SIL, input, 1 bit, serial input entering the LSB on shift left.
REQ-008 The block SHALL have port Q, output, WIDTH bits, register contents.
REQ-009 The block SHALL have port SOR, output, 1 bit, combinational copy of Q[0] (right-shift serial out).
REQ-010 The block SHALL have port SOL, output, 1 bit, combinational copy of Q[WIDTH-1] (left-shift serial out).
REQ-011 The block SHALL have port bit_cnt, output, clog2(WIDTH) bits, number of shifts since the last load, reset or wrap.
REQ-012 The block SHALL have port done, output, 1 bit, registered one-cycle pulse marking a completed WIDTH-shift frame.

Function
REQ-013 With mode 00, Q and bit_cnt SHALL hold, and SIR, SIL and D SHALL be ignored.
REQ-014 With mode 01, on each edge Q SHALL become {SIR, Q[WIDTH-1:1]}.
REQ-015 With mode 10, on each edge Q SHALL become {Q[WIDTH-2:0], SIL}.
REQ-016 With mode 11, on each edge Q SHALL become D, bit_cnt SHALL become 0, and done SHALL be 0 in the following cycle.
REQ-017 Each shift edge (mode 01 or 10) SHALL increment bit_cnt modulo WIDTH.
REQ-018 On a shift edge where bit_cnt equals WIDTH-1, bit_cnt SHALL wrap to 0, and done SHALL be 1 for exactly the following cycle.
REQ-019 On every edge not covered by REQ-018, done SHALL be 0.
REQ-020 Changing shift direction mid-frame SHALL NOT clear bit_cnt; left and right shifts count alike.
REQ-021 A load at any bit_cnt value SHALL abort the frame: bit_cnt goes to 0 and no done pulse is produced.
REQ-022 SOR and SOL SHALL follow Q with no register stage, so the bit shifted out on an edge is visible on SOR/SOL before that edge.
REQ-023 Latency from mode/data inputs to Q SHALL be one clock edge; there SHALL be no other pipeline stage.

Reset
REQ-024 While CLR is 1, Q SHALL be all zeros, and bit_cnt and done SHALL be 0, independent of clk.
REQ-025 Assertion of CLR SHALL take effect immediately (asynchronously), including mid-frame, and the partial frame SHALL be discarded.
REQ-026 After CLR deasserts, the first active edge SHALL operate normally per mode, with bit_cnt counting from 0.

Verification (WIDTH=8)
REQ-027 The bench SHALL cover: load D=0xA5 (mode 11) -> Q=0xA5, bit_cnt=0, done=0 after the edge; SOR=1, SOL=1.
REQ-028 The bench SHALL cover: from Q=0xA5, one shift right with SIR=1 -> Q=0xD2, bit_cnt=1; SOR goes from 1 to 0.
REQ-029 The bench SHALL cover: from Q=0xFF after load, 8 shift-lefts with SIL=0 -> Q=0x00, bit_cnt=0; done=1 only in the cycle after the 8th edge, then 0.
REQ-030 The bench SHALL cover: 5 shifts, then a load of 0x3C -> Q=0x3C, bit_cnt=0, and no done pulse; 8 further shifts -> exactly one done pulse.
REQ-031 The bench SHALL cover: mode 00 for 10 edges with SIR/SIL/D toggling -> Q and bit_cnt unchanged, done=0.
REQ-032 The bench SHALL cover: CLR pulsed between edges at bit_cnt=6 with Q=0x5A -> Q=0x00, bit_cnt=0 and done=0 before the next edge; the next 8 shifts -> one done pulse.

Source files
------------

// File: rtl/shift_reg_universal.sv
// +--------------------------------------------------------------------------+
// | shift_reg_universal: universal shift register with frame bit counter     |
// | and one-cycle done pulse after every WIDTH shifts.  Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_reg_universal #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     CLR,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         D,
  input  logic                     SIR,
  input  logic                     SIL,
  output logic [WIDTH-1:0]         Q,
  output logic                     SOR,
  output logic                     SOL,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0]       C_MODE_HOLD = 2'b00;
  localparam logic [1:0]       C_MODE_SHR  = 2'b01;
  localparam logic [1:0]       C_MODE_SHL  = 2'b10;
  localparam logic [1:0]       C_MODE_LOAD = 2'b11;
  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic             w_shift;

  always_comb begin
    q_d       = q_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    w_shift   = 1'b0;

    case (mode)
      C_MODE_SHR: begin
        q_d     = {SIR, q_q[WIDTH-1:1]};
        w_shift = 1'b1;
      end
      C_MODE_SHL: begin
        q_d     = {q_q[WIDTH-2:0], SIL};
        w_shift = 1'b1;
      end
      C_MODE_LOAD: begin
        // A load aborts any frame in progress without signalling done.
        q_d       = D;
        bit_cnt_d = '0;
      end
      C_MODE_HOLD: begin
        q_d = q_q;
      end
      default: begin
        q_d = q_q;
      end
    endcase

    // Both shift directions advance the same frame counter.
    if (w_shift) begin
      if (bit_cnt_q == C_CNT_LAST) begin
        bit_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      q_q       <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      q_q       <= q_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  assign Q       = q_q;
  assign bit_cnt = bit_cnt_q;
  assign done    = done_q;
  // Serial outputs are taken straight from the register, not re-registered.
  assign SOR     = q_q[0];
  assign SOL     = q_q[WIDTH-1];

endmodule

`default_nettype wire
